toggle_checker: RTL and testbench
=================================

// Module: toggle_checker
// PURPOSE
//  Response checker for the alternating-bit stimulus used in DFF/register tests: samples a 1-bit
//  stream on CLK and verifies it toggles every enabled sample. Hunts for lock, flags each broken
//  toggle once locked, keeps a saturating error count and drops lock after repeated misses.
//  Sits on the Q side of the unit under test; self-checking benches read LOCKED/ERR_CNT.
// PARAMETERS
//  LOCK_COUNT  4  consecutive good toggles required in HUNT to enter LOCKED (>=1)
//  LOSS_COUNT  2  consecutive misses (LOCKED/SLIP) that return the FSM to HUNT (>=1)
//  ERR_WIDTH   8  width of ERR_CNT
// PORTS
//  CLK      in   1          clock, all state updates on posedge
//  RST      in   1          asynchronous, active-high reset
//  EN       in   1          sample enable; low = hold all state, ERR=0
//  D        in   1          serial data under check
//  CLR      in   1          synchronous clear of ERR_CNT
//  LOCKED   out  1          1 while state is LOCKED or SLIP
//  ERR      out  1          one-cycle pulse per detected miss while locked
//  ERR_CNT  out  ERR_WIDTH  saturating count of misses
//  STATE    out  2          FSM state (debug)
// BEHAVIOUR
//  - Reset (async, RST=1): STATE=HUNT, LOCKED=0, ERR=0, ERR_CNT=0, prev/prev_vld=0, run=0, miss=0.
//  - All outputs registered; response appears 1 cycle after the sampling edge.
//  - Sample = posedge CLK with EN=1. First sample after reset/HUNT re-entry with prev_vld=0 only
//    loads prev, sets prev_vld; no compare. Every sample loads prev<=D.
//  - good = (D != prev); miss = (D == prev).
//  - HUNT(00): good -> run++; run reaching LOCK_COUNT -> LOCKED, run=0. miss -> run=0. ERR never set.
//  - LOCKED(01): good -> stay. miss -> ERR=1, ERR_CNT++, miss=1; if LOSS_COUNT==1 -> HUNT else SLIP.
//  - SLIP(10): good -> LOCKED, miss=0. miss -> ERR=1, ERR_CNT++, miss++; miss reaching LOSS_COUNT
//    -> HUNT, miss=0, run=0 (prev_vld stays 1; next sample compares normally).
//  - Encoding 11 illegal: next edge forces HUNT, no ERR.
//  - ERR_CNT saturates at all-ones; further misses still pulse ERR.
//  - CLR=1: ERR_CNT<=0; if a miss is detected on the same edge, ERR_CNT<=1 (clear then count).
//  - CLR acts regardless of EN. EN=0: STATE, prev, run, miss held; ERR=0.
//  - RST mid-stream: immediate return to reset values; relock needs 1 + LOCK_COUNT samples.
// STRUCTURE
//  - Shared package toggle_chk_pkg: state localparams ST_HUNT=2'b00, ST_LOCKED=2'b01,
//    ST_SLIP=2'b10; width for run/miss counters via $clog2(max(LOCK_COUNT,LOSS_COUNT)+1).
//  - Sub-module sat_counter (WIDTH param; inc, clr inputs; clr-then-inc priority) for ERR_CNT.
//  - FSM + prev/run/miss registers in top.
// TESTING
//  1 Reset, EN=1, D toggles 0,1,0,1,0 -> LOCKED rises 1 cycle after 5th sample; ERR_CNT=0.
//  2 Locked, repeat one bit (..1,0,0,1,0..) -> single ERR pulse, STATE 01->10->01, ERR_CNT=1.
//  3 Locked, D stuck at 1 for 3 samples -> ERR pulses on 2 samples, ERR_CNT=2, STATE=HUNT,
//    LOCKED=0; resume toggling -> relock after 4 good toggles.
//  4 ERR_WIDTH=2, force 5 misses via repeated lock/slip -> ERR_CNT sticks at 3, ERR pulses 5 times.
//  5 CLR on same edge as a miss with ERR_CNT=3 -> ERR_CNT=1; CLR alone -> 0.
//  6 EN low for 10 cycles mid-lock with D constant -> no ERR, STATE unchanged; RST pulse between
//    edges -> LOCKED=0 and ERR_CNT=0 immediately, before next CLK edge.

Source files
------------

// File: rtl/toggle_chk_pkg.sv
// Shared types and helpers for the alternating-bit response checker.
// FSM state encoding and counter sizing live here.
package toggle_chk_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_LOCKED = 2'b01,
    ST_SLIP   = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  // Bits needed to count up to the larger of the two thresholds.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/toggle_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins, but an increment on the same edge still counts once.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // Clear-then-count, holding at all-ones once full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? WIDTH'(1) : '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/toggle_checker.sv
// Checks that a 1-bit stream toggles on every enabled sample.
// Hunts for lock, flags misses while locked, drops lock on repeats.
module toggle_checker
  import toggle_chk_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 D,
  input  logic                 CLR,
  output logic                 LOCKED,
  output logic                 ERR,
  output logic [ERR_WIDTH-1:0] ERR_CNT,
  output logic [1:0]           STATE
);

  localparam int CW = cnt_width(LOCK_COUNT, LOSS_COUNT);
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] LOSS_N = CW'(LOSS_COUNT);

  state_t        state;
  logic          prev;
  logic          prev_vld;
  logic [CW-1:0] run;
  logic [CW-1:0] miss;
  logic          good;
  logic          hit;
  logic          in_lock;

  assign good    = (D != prev);
  assign in_lock = (state == ST_LOCKED) || (state == ST_SLIP);
  assign hit     = EN && prev_vld && !good && in_lock;
  assign STATE   = state;

  // Lock FSM plus previous-bit and run/miss bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_HUNT;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
      prev     <= 1'b0;
      prev_vld <= 1'b0;
      run      <= '0;
      miss     <= '0;
    end else begin
      ERR <= 1'b0;
      if (state == ST_BAD) begin
        state  <= ST_HUNT;
        LOCKED <= 1'b0;
        run    <= '0;
        miss   <= '0;
      end else if (EN) begin
        prev     <= D;
        prev_vld <= 1'b1;
        if (prev_vld) begin
          unique case (state)
            ST_HUNT: begin
              if (!good) begin
                run <= '0;
              end else if (run == LOCK_N - 1'b1) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
                run    <= '0;
              end else begin
                run <= run + 1'b1;
              end
            end
            ST_LOCKED: begin
              if (!good) begin
                ERR <= 1'b1;
                if (LOSS_COUNT == 1) begin
                  state  <= ST_HUNT;
                  LOCKED <= 1'b0;
                  run    <= '0;
                  miss   <= '0;
                end else begin
                  state <= ST_SLIP;
                  miss  <= CW'(1);
                end
              end
            end
            ST_SLIP: begin
              if (good) begin
                state <= ST_LOCKED;
                miss  <= '0;
              end else begin
                ERR <= 1'b1;
                if (miss == LOSS_N - 1'b1) begin
                  state  <= ST_HUNT;
                  LOCKED <= 1'b0;
                  miss   <= '0;
                  run    <= '0;
                end else begin
                  miss <= miss + 1'b1;
                end
              end
            end
            default: begin
              state  <= ST_HUNT;
              LOCKED <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  sat_counter #(
    .WIDTH(ERR_WIDTH)
  ) u_err_cnt (
    .clk(CLK),
    .rst(RST),
    .inc(hit),
    .clr(CLR),
    .cnt(ERR_CNT)
  );

endmodule

// File: tb/tb_toggle_checker.sv
// Scoreboard bench for toggle_checker: stimulus pushes expected
// responses, a monitor pops and compares after every clock edge.
module tb_toggle_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 2;
  localparam int EW   = 2;
  localparam int CMAX = (1 << EW) - 1;

  typedef struct {
    int locked;
    int err;
    int cnt;
    int st;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN  = 1'b0;
  logic          D   = 1'b0;
  logic          CLR = 1'b0;
  logic          LOCKED;
  logic          ERR;
  logic [EW-1:0] ERR_CNT;
  logic [1:0]    STATE;

  always #5 CLK = ~CLK;

  toggle_checker #(
    .LOCK_COUNT(LOCK),
    .LOSS_COUNT(LOSS),
    .ERR_WIDTH(EW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .D(D),
    .CLR(CLR),
    .LOCKED(LOCKED),
    .ERR(ERR),
    .ERR_CNT(ERR_CNT),
    .STATE(STATE)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Reference model: lock status plus streak lengths as plain integers.
  bit m_hunting;
  bit m_have_prev;
  bit m_prev;
  int m_good_streak;
  int m_miss_streak;
  int m_cnt;
  bit dcur;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hunting     = 1'b1;
    m_have_prev   = 1'b0;
    m_prev        = 1'b0;
    m_good_streak = 0;
    m_miss_streak = 0;
    m_cnt         = 0;
  endtask

  function automatic exp_t snapshot(input int err);
    exp_t e;
    e.locked = m_hunting ? 0 : 1;
    e.err    = err;
    e.cnt    = m_cnt;
    e.st     = m_hunting ? 0 : ((m_miss_streak > 0) ? 2 : 1);
    return e;
  endfunction

  task automatic model_step(input bit en, input bit d, input bit clr);
    int missed;
    missed = 0;
    if (en) begin
      if (m_have_prev) begin
        if (m_hunting) begin
          if (d != m_prev) begin
            m_good_streak++;
            if (m_good_streak == LOCK) begin
              m_hunting     = 1'b0;
              m_good_streak = 0;
              m_miss_streak = 0;
            end
          end else begin
            m_good_streak = 0;
          end
        end else if (d != m_prev) begin
          m_miss_streak = 0;
        end else begin
          missed = 1;
          m_miss_streak++;
          if (m_miss_streak == LOSS) begin
            m_hunting     = 1'b1;
            m_miss_streak = 0;
            m_good_streak = 0;
          end
        end
      end
      m_have_prev = 1'b1;
      m_prev      = d;
    end
    if (clr) m_cnt = missed;
    else if (missed != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
    q.push_back(snapshot(missed));
  endtask

  task automatic cycle(input bit en, input bit d, input bit clr);
    @(negedge CLK);
    RST = 1'b0;
    EN  = en;
    D   = d;
    CLR = clr;
    model_step(en, d, clr);
  endtask

  task automatic tog(input int n);
    for (int i = 0; i < n; i++) begin
      dcur = ~dcur;
      cycle(1'b1, dcur, 1'b0);
    end
  endtask

  task automatic rep(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, dcur, 1'b0);
  endtask

  task automatic rst_pulse();
    @(negedge CLK);
    EN  = 1'b0;
    CLR = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("async_locked", LOCKED, 0);
    chk("async_err_cnt", ERR_CNT, 0);
    chk("async_state", STATE, 0);
    #1 RST = 1'b0;
    model_reset();
  endtask

  // Monitor: compare DUT outputs with the oldest expectation each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked", LOCKED, e.locked);
        chk("err", ERR, e.err);
        chk("err_cnt", ERR_CNT, e.cnt);
        chk("state", STATE, e.st);
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    model_reset();
    dcur = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      q.push_back(snapshot(0));
    end
    tog(5);
    tog(2);
    rep(1);
    tog(2);
    tog(1);
    rep(2);
    tog(4);
    for (int i = 0; i < 3; i++) begin
      rep(1);
      tog(1);
    end
    rep(1);
    cycle(1'b1, dcur, 1'b1);
    tog(1);
    cycle(1'b0, dcur, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, dcur, 1'b0);
    rst_pulse();
    tog(5);
    for (int i = 0; i < 1500; i++) begin
      bit en;
      bit clr;
      if (i % 400 == 399) rst_pulse();
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 6) != 0) dcur = ~dcur;
      cycle(en, dcur, clr);
    end
    repeat (3) @(posedge CLK);
    #2;
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
